// File: rtl/guest_parking_ctrl.sv
// Guest parking lot controller: allocates the lowest free slot on entry (round-robin
// across gates) and releases slots on exit (fixed priority), one service of each per cycle.
module guest_parking_ctrl #(
    parameter  int N_SLOTS = 20,
    parameter  int N_GATES = 2,
    localparam int SW      = $clog2(N_SLOTS),
    localparam int CW      = $clog2(N_SLOTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_GATES-1:0]    entry_req,
    input  logic [N_GATES-1:0]    exit_req,
    input  logic [N_GATES*SW-1:0] exit_slot,
    output logic [N_GATES-1:0]    entry_grant,
    output logic [SW-1:0]         grant_slot,
    output logic [N_GATES-1:0]    entry_deny,
    output logic [N_GATES-1:0]    exit_done,
    output logic [N_GATES-1:0]    exit_err,
    output logic [CW-1:0]         avail,
    output logic                  full,
    output logic                  empty
);

    localparam int GW = (N_GATES > 1) ? $clog2(N_GATES) : 1;

    logic [N_SLOTS-1:0] r_occ;
    logic [CW-1:0]      r_avail;
    logic [GW-1:0]      r_rr;
    logic [N_GATES-1:0] r_entry_grant;
    logic [N_GATES-1:0] r_entry_deny;
    logic [N_GATES-1:0] r_exit_done;
    logic [N_GATES-1:0] r_exit_err;
    logic [SW-1:0]      r_grant_slot;

    logic [N_GATES-1:0] w_ent_elig;
    logic [N_GATES-1:0] w_ent_oh;
    logic               w_ent_hit;
    int                 w_best_d;
    int                 w_best_g;
    int                 w_dist;
    logic [GW-1:0]      w_rr_next;
    logic [N_GATES-1:0] w_ex_elig;
    logic [N_GATES-1:0] w_ex_oh;
    logic               w_ex_hit;
    logic [SW-1:0]      w_ex_slot;
    logic               w_ex_valid;
    logic [SW-1:0]      w_free;
    logic               w_do_grant;
    logic               w_do_rel;
    logic [N_SLOTS-1:0] w_occ_next;
    logic [CW-1:0]      w_avail_next;

    always_comb begin
        // A gate whose ack is currently high is ignored so a held request is not serviced twice.
        w_ent_elig = entry_req & ~(r_entry_grant | r_entry_deny);
        w_ex_elig  = exit_req & ~(r_exit_done | r_exit_err);

        w_best_d = N_GATES;
        w_best_g = 0;
        w_dist   = 0;
        for (int i = 0; i < N_GATES; i++) begin
            w_dist = (i - int'(r_rr) + N_GATES) % N_GATES;
            if (w_ent_elig[i] && (w_dist < w_best_d)) begin
                w_best_d = w_dist;
                w_best_g = i;
            end
        end
        w_ent_hit = (w_best_d < N_GATES);
        w_ent_oh  = '0;
        for (int i = 0; i < N_GATES; i++) begin
            if (w_ent_hit && (w_best_g == i)) w_ent_oh[i] = 1'b1;
        end
        w_rr_next = w_ent_hit ? GW'((w_best_g + 1) % N_GATES) : r_rr;

        w_ex_hit  = 1'b0;
        w_ex_oh   = '0;
        w_ex_slot = '0;
        for (int i = 0; i < N_GATES; i++) begin
            if (!w_ex_hit && w_ex_elig[i]) begin
                w_ex_hit   = 1'b1;
                w_ex_oh[i] = 1'b1;
                w_ex_slot  = exit_slot[i*SW +: SW];
            end
        end

        // Out-of-range slot numbers never match any s, so they fall out as invalid exits.
        w_ex_valid = 1'b0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if ((w_ex_slot == SW'(s)) && r_occ[s]) w_ex_valid = 1'b1;
        end

        w_free = '0;
        for (int s = N_SLOTS - 1; s >= 0; s--) begin
            if (!r_occ[s]) w_free = SW'(s);
        end

        w_do_grant = w_ent_hit && (r_avail != '0);
        w_do_rel   = w_ex_hit && w_ex_valid;

        // Entry allocates from the pre-release bitmap, so the set and clear never collide.
        w_occ_next = r_occ;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (w_do_grant && (w_free == SW'(s)))  w_occ_next[s] = 1'b1;
            if (w_do_rel && (w_ex_slot == SW'(s))) w_occ_next[s] = 1'b0;
        end
        w_avail_next = r_avail + CW'(w_do_rel) - CW'(w_do_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ         <= '0;
            r_avail       <= CW'(N_SLOTS);
            r_rr          <= '0;
            r_entry_grant <= '0;
            r_entry_deny  <= '0;
            r_exit_done   <= '0;
            r_exit_err    <= '0;
            r_grant_slot  <= '0;
        end else begin
            r_occ         <= w_occ_next;
            r_avail       <= w_avail_next;
            r_rr          <= w_rr_next;
            r_entry_grant <= w_do_grant ? w_ent_oh : '0;
            r_entry_deny  <= (w_ent_hit && !w_do_grant) ? w_ent_oh : '0;
            r_exit_done   <= w_do_rel ? w_ex_oh : '0;
            r_exit_err    <= (w_ex_hit && !w_ex_valid) ? w_ex_oh : '0;
            r_grant_slot  <= w_do_grant ? w_free : '0;
        end
    end

    assign entry_grant = r_entry_grant;
    assign entry_deny  = r_entry_deny;
    assign exit_done   = r_exit_done;
    assign exit_err    = r_exit_err;
    assign grant_slot  = r_grant_slot;
    assign avail       = r_avail;
    assign full        = (r_avail == '0);
    assign empty       = (r_avail == CW'(N_SLOTS));

endmodule

// File: tb/tb_guest_parking_ctrl.sv
// Bench for guest_parking_ctrl: slot-level model compared every cycle plus directed scenarios.
module tb_guest_parking_ctrl;

    localparam int NS = 4;
    localparam int NG = 2;
    localparam int SW = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NG-1:0]    entry_req, exit_req;
    logic [NG*SW-1:0] exit_slot;
    logic [NG-1:0]    entry_grant, entry_deny, exit_done, exit_err;
    logic [SW-1:0]    grant_slot;
    logic [CW-1:0]    avail;
    logic             full, empty;

    logic [1:0] entry_req5, exit_req5;
    logic [5:0] exit_slot5;
    logic [1:0] entry_grant5, entry_deny5, exit_done5, exit_err5;
    logic [2:0] grant_slot5;
    logic [2:0] avail5;
    logic       full5, empty5;

    guest_parking_ctrl #(.N_SLOTS(NS), .N_GATES(NG)) dut (
        .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
        .exit_slot(exit_slot), .entry_grant(entry_grant), .grant_slot(grant_slot),
        .entry_deny(entry_deny), .exit_done(exit_done), .exit_err(exit_err),
        .avail(avail), .full(full), .empty(empty)
    );

    guest_parking_ctrl #(.N_SLOTS(5), .N_GATES(2)) dut5 (
        .clk(clk), .rst(rst), .entry_req(entry_req5), .exit_req(exit_req5),
        .exit_slot(exit_slot5), .entry_grant(entry_grant5), .grant_slot(grant_slot5),
        .entry_deny(entry_deny5), .exit_done(exit_done5), .exit_err(exit_err5),
        .avail(avail5), .full(full5), .empty(empty5)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the lot is an array of parked flags; free count is derived, never stored.
    bit         m_occ [NS];
    logic [1:0] m_grant = '0, m_deny = '0, m_done = '0, m_err = '0;
    int         m_gslot = 0;
    int         m_rr = 0;

    function automatic int free_cnt();
        int n = 0;
        for (int s = 0; s < NS; s++) if (!m_occ[s]) n++;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [1:0] ee, xe;
        bit pre [NS];
        int g, sl, f;
        bit done_e;
        if (rst) begin
            for (int s = 0; s < NS; s++) m_occ[s] = 1'b0;
            m_grant = '0; m_deny = '0; m_done = '0; m_err = '0;
            m_gslot = 0; m_rr = 0;
        end else begin
            ee = entry_req & ~(m_grant | m_deny);
            xe = exit_req & ~(m_done | m_err);
            m_grant = '0; m_deny = '0; m_done = '0; m_err = '0; m_gslot = 0;
            pre = m_occ;
            done_e = 1'b0;
            for (int k = 0; k < NG; k++) begin
                g = (m_rr + k) % NG;
                if (!done_e && ee[g]) begin
                    done_e = 1'b1;
                    if (free_cnt() > 0) begin
                        f = 0;
                        while (m_occ[f]) f++;
                        m_occ[f] = 1'b1;
                        m_grant[g] = 1'b1;
                        m_gslot = f;
                    end else begin
                        m_deny[g] = 1'b1;
                    end
                    m_rr = (g + 1) % NG;
                end
            end
            for (int gi = 0; gi < NG; gi++) begin
                if (xe[gi] && (m_done == 0) && (m_err == 0)) begin
                    sl = int'(exit_slot[gi*SW +: SW]);
                    if (sl < NS && pre[sl]) begin
                        m_occ[sl] = 1'b0;
                        m_done[gi] = 1'b1;
                    end else begin
                        m_err[gi] = 1'b1;
                    end
                end
            end
        end
    end

    bit run_cmp = 1'b0;
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cyc_entry_grant", int'(entry_grant), int'(m_grant));
            chk("cyc_entry_deny", int'(entry_deny), int'(m_deny));
            chk("cyc_exit_done", int'(exit_done), int'(m_done));
            chk("cyc_exit_err", int'(exit_err), int'(m_err));
            chk("cyc_avail", int'(avail), free_cnt());
            chk("cyc_full", int'(full), int'(free_cnt() == 0));
            chk("cyc_empty", int'(empty), int'(free_cnt() == NS));
            if (m_grant != 0) chk("cyc_grant_slot", int'(grant_slot), m_gslot);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 1 = grant/done, 2 = deny/err, 0 = no ack within budget
    task automatic do_entry(input int g, output int kind, output int slot);
        int lat;
        entry_req[g] = 1'b1;
        kind = 0; slot = -1; lat = -1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (entry_grant[g]) begin kind = 1; slot = int'(grant_slot); lat = c; break; end
            if (entry_deny[g])  begin kind = 2; lat = c; break; end
        end
        entry_req[g] = 1'b0;
        chk("entry_latency", lat, 0);
        tick();
    endtask

    task automatic do_exit(input int g, input int s, output int kind);
        int lat;
        exit_slot[g*SW +: SW] = s[SW-1:0];
        exit_req[g] = 1'b1;
        kind = 0; lat = -1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (exit_done[g]) begin kind = 1; lat = c; break; end
            if (exit_err[g])  begin kind = 2; lat = c; break; end
        end
        exit_req[g] = 1'b0;
        chk("exit_latency", lat, 0);
        tick();
    endtask

    int kind, slot;

    initial begin
        rst = 1'b1;
        entry_req = '0; exit_req = '0; exit_slot = '0;
        entry_req5 = '0; exit_req5 = '0; exit_slot5 = '0;
        repeat (3) tick();
        run_cmp = 1'b1;
        chk("rst_avail", int'(avail), 4);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_grant_slot", int'(grant_slot), 0);
        chk("rst_acks", int'({entry_grant, entry_deny, exit_done, exit_err}), 0);
        rst = 1'b0;

        // Five-slot lot: slot 7 does not exist
        exit_slot5[2:0] = 3'd7;
        exit_req5[0] = 1'b1;
        tick();
        chk("n5_slot7_err", int'(exit_err5), 1);
        chk("n5_slot7_done", int'(exit_done5), 0);
        chk("n5_avail", int'(avail5), 5);
        exit_req5 = '0;
        tick();

        for (int i = 0; i < 4; i++) begin
            do_entry(0, kind, slot);
            chk("fill_kind", kind, 1);
            chk("fill_slot", slot, i);
            chk("fill_avail", int'(avail), 3 - i);
        end
        chk("fill_full", int'(full), 1);
        chk("model_full_pin", free_cnt(), 0);

        do_entry(1, kind, slot);
        chk("full_deny_kind", kind, 2);
        chk("full_deny_avail", int'(avail), 0);

        // Exit slot 1 on gate0 while gate1 asks to enter a full lot
        exit_slot[1:0] = 2'd1;
        exit_req[0] = 1'b1;
        entry_req[1] = 1'b1;
        tick();
        chk("conc_exit_done", int'(exit_done), 1);
        chk("conc_entry_deny", int'(entry_deny), 2);
        chk("conc_avail", int'(avail), 1);
        exit_req = '0; entry_req = '0;
        tick();
        do_entry(1, kind, slot);
        chk("conc_regrant_kind", kind, 1);
        chk("conc_regrant_slot", slot, 1);

        do_exit(0, 2, kind);
        chk("exit2_kind", kind, 1);
        do_exit(0, 2, kind);
        chk("exit2_again_err", kind, 2);
        chk("exit2_again_avail", int'(avail), 1);
        do_exit(0, 5, kind);
        chk("exit5_trunc_kind", kind, 1);
        chk("exit5_trunc_avail", int'(avail), 2);
        do_exit(1, 0, kind);
        chk("exit0_kind", kind, 1);
        do_exit(1, 3, kind);
        chk("exit3_kind", kind, 1);
        chk("drain_empty", int'(empty), 1);
        chk("model_empty_pin", free_cnt(), 4);

        // Both gates hold entry_req straight out of reset
        rst = 1'b1;
        entry_req = 2'b11;
        repeat (2) tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rr_gate", int'(entry_grant), (c % 2 == 0) ? 1 : 2);
            chk("rr_slot", int'(grant_slot), c);
        end
        entry_req = '0;
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_entry(0, kind, slot);
        do_entry(0, kind, slot);
        chk("mid_pre_avail", int'(avail), 2);
        entry_req[0] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async_avail", int'(avail), 4);
        chk("mid_async_empty", int'(empty), 1);
        chk("mid_async_full", int'(full), 0);
        chk("mid_async_grant", int'(entry_grant), 0);
        tick();
        chk("mid_hold_acks", int'({entry_grant, entry_deny}), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_grant", int'(entry_grant), 1);
        chk("post_rst_slot", int'(grant_slot), 0);
        chk("post_rst_avail", int'(avail), 3);
        entry_req = '0;
        repeat (2) tick();

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
